// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master round-robin arbiter in front of the single RAM/IO slave.
// Master 0 is the CPU data port; master 1 is the DMA/UART loader. Ownership
// is bounded: while the other master is waiting, the owner keeps the bus for
// at most MAX_BURST beats and then hands it over.
//
// Ports
//   C, R                  clock, synchronous active-high reset
//   Req0/1                master holds high while it wants the bus
//   Addr0/1, WData0/1     master address / write data
//   Read0/1, Write0/1     master strobes (write wins when both are set)
//   Gnt0/1                registered grants, mutually exclusive
//   RData0/1              BusRData while that master is granted, else 0
//   BusAddr, BusWData     address / write data to the slave
//   BusRead, BusWrite     strobes to the slave
//   BusRData              combinational read data from the slave
//   Owner                 last or current owner (round-robin pointer)
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 4   // legal range 1..255
) (
    input  logic        C,
    input  logic        R,

    input  logic        Req0,
    input  logic [31:0] Addr0,
    input  logic        Read0,
    input  logic        Write0,
    input  logic [31:0] WData0,
    output logic        Gnt0,
    output logic [31:0] RData0,

    input  logic        Req1,
    input  logic [31:0] Addr1,
    input  logic        Read1,
    input  logic        Write1,
    input  logic [31:0] WData1,
    output logic        Gnt1,
    output logic [31:0] RData1,

    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic        BusRead,
    output logic        BusWrite,
    input  logic [31:0] BusRData,

    output logic        Owner
);

    // Encoding chosen so each grant is a single state flop.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     state;
    logic [7:0] beat_cnt;

    // View of the current owner and the waiting master, used by both the
    // bus mux and the transition logic.
    logic       cur_req;
    logic       cur_read;
    logic       cur_write;
    logic       oth_req;
    logic       beat;
    state_t     oth_state;
    logic       oth_idx;

    assign Gnt0 = state[0];
    assign Gnt1 = state[1];

    // NOTE: every signal gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cur_req   = 1'b0;
        cur_read  = 1'b0;
        cur_write = 1'b0;
        oth_req   = 1'b0;
        oth_state = IDLE;
        oth_idx   = 1'b0;
        BusAddr   = '0;
        BusWData  = '0;
        case (state)
            OWN0: begin
                cur_req   = Req0;
                cur_read  = Read0;
                cur_write = Write0;
                oth_req   = Req1;
                oth_state = OWN1;
                oth_idx   = 1'b1;
                BusAddr   = Addr0;
                BusWData  = WData0;
            end
            OWN1: begin
                cur_req   = Req1;
                cur_read  = Read1;
                cur_write = Write1;
                oth_req   = Req0;
                oth_state = OWN0;
                oth_idx   = 1'b0;
                BusAddr   = Addr1;
                BusWData  = WData1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by the owner's own request, so an owner releasing
    // the bus issues nothing in its release cycle.
    assign BusWrite = cur_req & cur_write;
    assign BusRead  = cur_req & cur_read & ~cur_write;
    assign beat     = cur_req & (cur_read | cur_write);

    assign RData0 = Gnt0 ? BusRData : '0;
    assign RData1 = Gnt1 ? BusRData : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge C) begin
        if (R) begin
            state    <= IDLE;
            beat_cnt <= '0;
            Owner    <= 1'b1;   // master 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    // On a tie the master that is not the last owner wins.
                    if (Req0 && (!Req1 || Owner)) begin
                        state <= OWN0;
                        Owner <= 1'b0;
                    end else if (Req1) begin
                        state <= OWN1;
                        Owner <= 1'b1;
                    end
                end

                OWN0, OWN1: begin
                    if (!cur_req) begin
                        beat_cnt <= '0;
                        if (oth_req) begin
                            state <= oth_state;   // direct handoff
                            Owner <= oth_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (oth_req && beat && beat_cnt == LAST_BEAT) begin
                        // Burst limit reached with the other master waiting.
                        beat_cnt <= '0;
                        state    <= oth_state;
                        Owner    <= oth_idx;
                    end else if (beat && beat_cnt != LAST_BEAT) begin
                        // Saturates at LAST_BEAT while the owner is alone.
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter (MAX_BURST = 4). A small slave model holds
// 32 RAM words at 0x0000_0000..0x0000_007C and returns 0x0000_00A5 for the
// switch register at 0x4000_0010. Inputs change and outputs are sampled on
// the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        C = 1'b0;
    logic        R;
    logic        Req0, Read0, Write0, Req1, Read1, Write1;
    logic [31:0] Addr0, WData0, Addr1, WData1;
    logic        Gnt0, Gnt1, BusRead, BusWrite, Owner;
    logic [31:0] RData0, RData1, BusAddr, BusWData, BusRData;

    localparam logic [31:0] SWITCH_ADDR = 32'h4000_0010;
    localparam logic [31:0] SWITCH_VAL  = 32'h0000_00A5;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 C = ~C;

    bus_arbiter #(.MAX_BURST(4)) dut (
        .C(C), .R(R),
        .Req0(Req0), .Addr0(Addr0), .Read0(Read0), .Write0(Write0),
        .WData0(WData0), .Gnt0(Gnt0), .RData0(RData0),
        .Req1(Req1), .Addr1(Addr1), .Read1(Read1), .Write1(Write1),
        .WData1(WData1), .Gnt1(Gnt1), .RData1(RData1),
        .BusAddr(BusAddr), .BusWData(BusWData), .BusRead(BusRead),
        .BusWrite(BusWrite), .BusRData(BusRData), .Owner(Owner)
    );

    // Slave model: RAM commits on the rising edge, reads are combinational.
    logic [31:0] mem [0:31] = '{default: 32'h0};

    always @(posedge C)
        if (BusWrite && BusAddr[31:7] == 25'd0)
            mem[BusAddr[6:2]] <= BusWData;

    always_comb begin
        BusRData = 32'h0;
        if (BusAddr == SWITCH_ADDR)
            BusRData = SWITCH_VAL;
        else if (BusAddr[31:7] == 25'd0)
            BusRData = mem[BusAddr[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(negedge C);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        R = 1'b1;
        Req0 = 0; Read0 = 0; Write0 = 0; Addr0 = 0; WData0 = 0;
        Req1 = 0; Read1 = 0; Write1 = 0; Addr1 = 0; WData1 = 0;

        // ---- Reset with both masters requesting ----
        Req0 = 1; Read0 = 1; Addr0 = 32'h10;
        Req1 = 1; Read1 = 1; Addr1 = 32'h14;
        repeat (2) @(posedge C);
        nx();
        check("rst_gnt0",     Gnt0,     0);
        check("rst_gnt1",     Gnt1,     0);
        check("rst_owner",    Owner,    1);
        check("rst_busread",  BusRead,  0);
        check("rst_buswrite", BusWrite, 0);
        check("rst_busaddr",  BusAddr,  0);
        check("rst_rdata0",   RData0,   0);
        check("rst_rdata1",   RData1,   0);
        R = 0;
        nx();
        check("first_tie_gnt0",  Gnt0,  1);
        check("first_tie_gnt1",  Gnt1,  0);
        check("first_tie_owner", Owner, 0);
        #1;
        check("first_beat_read", BusRead, 1);
        check("first_beat_addr", BusAddr, 32'h10);
        // Owner releases with its read strobe still set.
        Req0 = 0; Req1 = 0;
        #1;
        check("release_no_read", BusRead, 0);
        nx();
        check("release_idle_gnt0", Gnt0, 0);
        check("release_idle_gnt1", Gnt1, 0);
        Read0 = 0; Read1 = 0; Addr0 = 0; Addr1 = 0;

        // ---- Single master 1: write then read back ----
        Req1 = 1; Write1 = 1; Addr1 = 32'h10; WData1 = 32'hDEAD_BEEF;
        #1;
        check("m1_latency_gnt1",  Gnt1,     0);
        check("m1_latency_write", BusWrite, 0);
        nx();
        check("m1_gnt1",  Gnt1,  1);
        check("m1_owner", Owner, 1);
        #1;
        check("m1_buswrite", BusWrite, 1);
        check("m1_busread",  BusRead,  0);
        check("m1_busaddr",  BusAddr,  32'h10);
        check("m1_buswdata", BusWData, 32'hDEAD_BEEF);
        nx();
        Write1 = 0; Read1 = 1;
        #1;
        check("m1_rd_write",  BusWrite, 0);
        check("m1_rd_read",   BusRead,  1);
        check("m1_rd_rdata1", RData1,   32'hDEAD_BEEF);
        check("m1_rd_rdata0", RData0,   0);
        nx();
        Req1 = 0; Read1 = 0; Write1 = 1;
        #1;
        check("m1_drop_nowrite", BusWrite, 0);
        nx();
        check("m1_drop_gnt1", Gnt1, 0);
        check("m1_drop_gnt0", Gnt0, 0);
        Write1 = 0; Addr1 = 0; WData1 = 0;

        // ---- Burst limit: master 0 streams, master 1 joins on beat 2 ----
        Req0 = 1; Read0 = 1; Addr0 = 32'h10;
        for (int b = 1; b <= 4; b++) begin
            nx();
            check($sformatf("burst%0d_gnt0", b), Gnt0, 1);
            check($sformatf("burst%0d_gnt1", b), Gnt1, 0);
            if (b == 2) begin
                Req1 = 1; Read1 = 1; Addr1 = SWITCH_ADDR;
            end
            #1;
            check($sformatf("burst%0d_read", b),   BusRead, 1);
            check($sformatf("burst%0d_addr", b),   BusAddr, 32'h10);
            check($sformatf("burst%0d_rdata0", b), RData0,  32'hDEAD_BEEF);
            check($sformatf("burst%0d_rdata1", b), RData1,  0);
        end
        nx();
        check("rot_gnt0",  Gnt0,  0);
        check("rot_gnt1",  Gnt1,  1);
        check("rot_owner", Owner, 1);
        #1;
        check("rot_busaddr", BusAddr, SWITCH_ADDR);
        check("rot_rdata1",  RData1,  SWITCH_VAL);
        check("rot_rdata0",  RData0,  0);
        nx();
        check("m1_second_beat_gnt1", Gnt1, 1);
        Req1 = 0; Read1 = 0;
        #1;
        check("m1_release_noread", BusRead, 0);
        nx();
        check("handback_gnt0",  Gnt0,  1);
        check("handback_gnt1",  Gnt1,  0);
        check("handback_owner", Owner, 0);
        Addr1 = 0;

        // ---- Round-robin tie from IDLE with Owner = 0 ----
        Req0 = 0; Read0 = 0;
        nx();
        check("tie_pre_idle",  Gnt0,  0);
        check("tie_pre_owner", Owner, 0);
        Req0 = 1; Req1 = 1;
        nx();
        check("tie_gnt1",  Gnt1,  1);
        check("tie_gnt0",  Gnt0,  0);
        check("tie_owner", Owner, 1);
        // No beats from master 1, so no forced rotation.
        repeat (5) nx();
        check("tie_nobeat_hold", Gnt1, 1);
        Req0 = 0; Req1 = 0;
        nx();
        check("tie_end_idle", Gnt1, 0);

        // ---- Peripheral read by master 0, master 1 strobes ignored ----
        Req0 = 1; Read0 = 1; Addr0 = SWITCH_ADDR;
        Write1 = 1; Read1 = 1; Addr1 = 32'h20; WData1 = 32'h0000_1234;
        nx();
        check("periph_gnt0", Gnt0, 1);
        #1;
        check("periph_busaddr", BusAddr,  SWITCH_ADDR);
        check("periph_busread", BusRead,  1);
        check("periph_nowrite", BusWrite, 0);
        check("periph_rdata0",  RData0,   SWITCH_VAL);
        check("periph_rdata1",  RData1,   0);
        // Both strobes set: write wins.
        Write0 = 1; Addr0 = 32'h14; WData0 = 32'hCAFE_0001;
        #1;
        check("wwins_write", BusWrite, 1);
        check("wwins_read",  BusRead,  0);
        check("wwins_wdata", BusWData, 32'hCAFE_0001);
        nx();
        Write0 = 0;
        #1;
        check("wwins_readback", RData0, 32'hCAFE_0001);
        Addr0 = 32'h20;
        #1;
        check("m1_write_ignored", RData0, 0);
        Write1 = 0; Read1 = 0; Addr1 = 0; WData1 = 0;

        // ---- Saturated BeatCnt: rotation on the very next beat ----
        repeat (3) nx();
        check("sat_hold_gnt0", Gnt0, 1);
        Req1 = 1;
        nx();
        check("sat_rot_gnt1", Gnt1, 1);
        check("sat_rot_gnt0", Gnt0, 0);
        Req1 = 0;
        nx();
        check("sat_back_gnt0",  Gnt0,  1);
        check("sat_back_owner", Owner, 0);

        // ---- Reset mid-transaction: the write still reaches the slave ----
        Read0 = 0; Write0 = 1; Addr0 = 32'h18; WData0 = 32'h55AA_00FF; R = 1;
        #1;
        check("rst_mid_write", BusWrite, 1);
        nx();
        check("rst_mid_gnt0",  Gnt0,  0);
        check("rst_mid_owner", Owner, 1);
        R = 0; Write0 = 0; Read0 = 1;
        nx();
        check("rst_after_gnt0", Gnt0, 1);
        #1;
        check("rst_write_committed", RData0, 32'h55AA_00FF);

        Req0 = 0; Read0 = 0;
        nx();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
